// File: rtl/vga_pkg.sv
// Shared VGA geometry and obstacle controller state type.
//   HOR_PIXELS / VER_PIXELS : visible display size used to derive wall limits
//   state_t                 : obstacle motion FSM encoding
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/axis_bounce.sv
// Single-axis move-and-bounce arithmetic (combinational).
//   pos      : current edge position
//   dir_neg  : 0 = moving toward MAX, 1 = moving toward 0
//   speed    : step size in pixels
//   pos_next : position after the step, clamped to [0, MAX]
//   hit      : step reached a wall; caller flips the direction
module axis_bounce #(
    parameter int MAX = 699
) (
    input  logic [11:0] pos,
    input  logic        dir_neg,
    input  logic [3:0]  speed,
    output logic [11:0] pos_next,
    output logic        hit
);

    localparam logic [12:0] MAX13 = 13'(MAX);

    logic [12:0] pos13;
    logic [12:0] spd13;
    logic [12:0] sum13;

    assign pos13 = {1'b0, pos};
    assign spd13 = {9'd0, speed};
    assign sum13 = pos13 + spd13;

    always_comb begin
        pos_next = pos;
        hit      = 1'b0;
        // A zero step must never count as touching a wall, even when parked on one.
        if (speed != 4'd0) begin
            if (!dir_neg) begin
                if (sum13 >= MAX13) begin
                    pos_next = MAX13[11:0];
                    hit      = 1'b1;
                end else begin
                    pos_next = sum13[11:0];
                end
            end else begin
                if (pos13 <= spd13) begin
                    pos_next = 12'd0;
                    hit      = 1'b1;
                end else begin
                    pos_next = pos - {8'd0, speed};
                end
            end
        end
    end

endmodule

// File: rtl/obstacle_ctrl.sv
// Bouncing obstacle sprite controller: moves a W x L rectangle once per frame
// and reflects it off the screen edges.
//   clk, rst_n          : pixel clock, async active-low reset
//   vblnk               : vertical blank; its rising edge is the frame tick
//   start / stop        : run / pause requests (stop has priority)
//   speed               : pixels per frame on each axis, latched at the tick
//   xpos_rect/ypos_rect : sprite top-left corner to draw_rect
//   moving              : FSM in RUN
//   bounce              : one-clk pulse when either axis hits a wall
//   frame_cnt           : ticks seen while running (wraps)
//
// state    | meaning
// ST_IDLE  | after reset, parked at (X_INIT, Y_INIT), waiting for start
// ST_RUN   | moving one step per frame, counting frames
// ST_PAUSE | frozen position/direction/count, waiting for start
module obstacle_ctrl
    import vga_pkg::*;
#(
    parameter int W      = 100,
    parameter int L      = 100,
    parameter int X_INIT = 0,
    parameter int Y_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic        start,
    input  logic        stop,
    input  logic [3:0]  speed,
    output logic [11:0] xpos_rect,
    output logic [11:0] ypos_rect,
    output logic        moving,
    output logic        bounce,
    output logic [15:0] frame_cnt
);

    localparam int XMAX = HOR_PIXELS - L - 1;
    localparam int YMAX = VER_PIXELS - W - 1;

    state_t      state_q, state_d;
    logic        vblnk_q;
    logic        upd_q, upd_d;
    logic [3:0]  speed_q, speed_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        dxn_q, dxn_d;
    logic        dyn_q, dyn_d;
    logic        bounce_q, bounce_d;
    logic [15:0] fcnt_q, fcnt_d;

    logic        tick;
    logic [11:0] x_next, y_next;
    logic        x_hit, y_hit;

    assign tick = vblnk & ~vblnk_q;

    axis_bounce #(.MAX(XMAX)) u_axis_x (
        .pos      (xpos_q),
        .dir_neg  (dxn_q),
        .speed    (speed_q),
        .pos_next (x_next),
        .hit      (x_hit)
    );

    axis_bounce #(.MAX(YMAX)) u_axis_y (
        .pos      (ypos_q),
        .dir_neg  (dyn_q),
        .speed    (speed_q),
        .pos_next (y_next),
        .hit      (y_hit)
    );

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        upd_d    = 1'b0;
        fcnt_d   = fcnt_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        dxn_d    = dxn_q;
        dyn_d    = dyn_q;
        bounce_d = 1'b0;

        unique case (state_q)
            ST_IDLE:  if (start && !stop) state_d = ST_RUN;
            ST_RUN:   if (stop)           state_d = ST_PAUSE;
            ST_PAUSE: if (start && !stop) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        if (tick) speed_d = speed;

        // The move is deferred one cycle so it uses the speed latched at the
        // tick and lands while vblank is still high.
        if (tick && state_q == ST_RUN) begin
            upd_d  = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
        end

        if (upd_q) begin
            xpos_d   = x_next;
            ypos_d   = y_next;
            dxn_d    = dxn_q ^ x_hit;
            dyn_d    = dyn_q ^ y_hit;
            bounce_d = x_hit | y_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vblnk_q  <= 1'b0;
            upd_q    <= 1'b0;
            speed_q  <= 4'd0;
            xpos_q   <= 12'(X_INIT);
            ypos_q   <= 12'(Y_INIT);
            dxn_q    <= 1'b0;
            dyn_q    <= 1'b0;
            bounce_q <= 1'b0;
            fcnt_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            vblnk_q  <= vblnk;
            upd_q    <= upd_d;
            speed_q  <= speed_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            dxn_q    <= dxn_d;
            dyn_q    <= dyn_d;
            bounce_q <= bounce_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign xpos_rect = xpos_q;
    assign ypos_rect = ypos_q;
    assign moving    = (state_q == ST_RUN);
    assign bounce    = bounce_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_obstacle_ctrl.sv
// Bench for obstacle_ctrl: three instances share stimulus.
//   dut0 : defaults, rest at (0,0)
//   dut1 : X_INIT=697, near the right wall (XMAX=699)
//   dut2 : L=700, W=500 so XMAX=YMAX=99, rest at (96,96) for corner hits
module tb_obstacle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblnk = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  speed = 4'd0;

    logic [11:0] x0, y0, x1, y1, x2, y2;
    logic        mov0, mov1, mov2, bnc0, bnc1, bnc2;
    logic [15:0] fc0, fc1, fc2;

    int errors = 0;
    int checks = 0;
    int b1, b2;

    always #5 clk = ~clk;

    obstacle_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .start(start), .stop(stop), .speed(speed),
        .xpos_rect(x0), .ypos_rect(y0), .moving(mov0), .bounce(bnc0), .frame_cnt(fc0)
    );

    obstacle_ctrl #(.X_INIT(697)) dut1 (
        .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .start(start), .stop(stop), .speed(speed),
        .xpos_rect(x1), .ypos_rect(y1), .moving(mov1), .bounce(bnc1), .frame_cnt(fc1)
    );

    obstacle_ctrl #(.W(500), .L(700), .X_INIT(96), .Y_INIT(96)) dut2 (
        .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .start(start), .stop(stop), .speed(speed),
        .xpos_rect(x2), .ypos_rect(y2), .moving(mov2), .bounce(bnc2), .frame_cnt(fc2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        vblnk = 1'b0;
        speed = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full frame: low, rising edge, high long enough for the update, low.
    task automatic frame();
        b1 = 0;
        b2 = 0;
        vblnk = 1'b0;
        repeat (2) @(negedge clk);
        vblnk = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bnc1) b1++;
            if (bnc2) b2++;
        end
        vblnk = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bnc1) b1++;
            if (bnc2) b2++;
        end
    endtask

    // Position of dut0 may only change while vblnk is high (reset excepted).
    logic [11:0] prev_x, prev_y;
    logic        rst_seen = 1'b0;
    always @(negedge clk) begin
        if (rst_n && rst_seen) begin
            if (x0 !== prev_x || y0 !== prev_y) begin
                checks++;
                if (!vblnk) begin
                    errors++;
                    $display("FAIL move_outside_vblank: x=%0d y=%0d vblnk=%0b required 1", x0, y0, vblnk);
                end
            end
        end
        prev_x   = x0;
        prev_y   = y0;
        rst_seen = rst_n;
    end

    typedef struct {
        logic       st;
        logic       sp;
        logic [3:0] spd;
        logic       frm;
        int         ex;
        int         ey;
        int         emov;
        int         ef;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'd4, 1'b0,  0,  0, 1, 0};  // IDLE -> RUN
        tbl[1] = '{1'b0, 1'b0, 4'd4, 1'b1,  4,  4, 1, 1};
        tbl[2] = '{1'b0, 1'b0, 4'd4, 1'b1,  8,  8, 1, 2};
        tbl[3] = '{1'b0, 1'b0, 4'd4, 1'b1, 12, 12, 1, 3};
        tbl[4] = '{1'b1, 1'b1, 4'd4, 1'b0, 12, 12, 0, 3};  // stop wins
        tbl[5] = '{1'b0, 1'b0, 4'd9, 1'b1, 12, 12, 0, 3};  // paused frame
        tbl[6] = '{1'b1, 1'b0, 4'd4, 1'b0, 12, 12, 1, 3};  // resume
        tbl[7] = '{1'b0, 1'b0, 4'd0, 1'b1, 12, 12, 1, 4};  // speed 0
        tbl[8] = '{1'b0, 1'b0, 4'd2, 1'b1, 14, 14, 1, 5};
        tbl[9] = '{1'b0, 1'b0, 4'd7, 1'b1, 21, 21, 1, 6};  // speed 2 -> 7 before edge

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_x0", int'(x0), 0);
        check("rst_y0", int'(y0), 0);
        check("rst_mov0", int'(mov0), 0);
        check("rst_bnc0", int'(bnc0), 0);
        check("rst_fc0", int'(fc0), 0);
        check("rst_x1", int'(x1), 697);
        check("rst_x2", int'(x2), 96);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven run/pause/speed sequence on dut0
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st;
            stop  = tbl[i].sp;
            speed = tbl[i].spd;
            if (tbl[i].frm) frame();
            else @(negedge clk);
            check($sformatf("vec%0d_x", i), int'(x0), tbl[i].ex);
            check($sformatf("vec%0d_y", i), int'(y0), tbl[i].ey);
            check($sformatf("vec%0d_moving", i), int'(mov0), tbl[i].emov);
            check($sformatf("vec%0d_fcnt", i), int'(fc0), tbl[i].ef);
        end
        start = 1'b0;

        // Speed changed while vblnk low, after the previous tick: new value used
        speed = 4'd2;
        vblnk = 1'b0;
        repeat (3) @(negedge clk);
        speed = 4'd7;
        frame();
        check("midframe_speed_x", int'(x0), 28);

        // Right-wall clamp and bounce on dut1
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        speed = 4'd5;
        frame();
        check("xwall_x", int'(x1), 699);
        check("xwall_y", int'(y1), 5);
        check("xwall_bounce_cycles", b1, 1);
        frame();
        check("xwall_next_x", int'(x1), 694);
        check("xwall_next_bounce_cycles", b1, 0);

        // Reset between tick and update: aborted, then needs a fresh edge
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        speed = 4'd4;
        frame();
        check("pre_rst_x", int'(x0), 4);
        vblnk = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_now_x", int'(x0), 0);
        check("rst_now_fcnt", int'(fc0), 0);
        check("rst_now_moving", int'(mov0), 0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_after_x", int'(x0), 0);
        check("rst_after_y", int'(y0), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("no_edge_x", int'(x0), 0);
        check("no_edge_fcnt", int'(fc0), 0);
        frame();
        check("new_edge_x", int'(x0), 4);
        check("new_edge_fcnt", int'(fc0), 1);

        // Corner: dut2 hits both max walls, runs back, hits both zero walls
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        speed = 4'd3;
        frame();
        check("corner_max_x", int'(x2), 99);
        check("corner_max_y", int'(y2), 99);
        check("corner_max_bounce", b2, 1);
        for (int i = 0; i < 32; i++) frame();
        check("corner_run_x", int'(x2), 3);
        check("corner_run_y", int'(y2), 3);
        frame();
        check("corner_zero_x", int'(x2), 0);
        check("corner_zero_y", int'(y2), 0);
        check("corner_zero_bounce", b2, 1);
        frame();
        check("corner_out_x", int'(x2), 3);
        check("corner_out_y", int'(y2), 3);
        check("corner_out_bounce", b2, 0);
        check("corner_fcnt", int'(fc2), 35);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
